// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the program counter, issues one IMEM request at a
// time, holds each fetched word for decode and applies execute redirects,
// including redirects that land while a request is still outstanding.
//
// Handshakes:
//   imem_req/imem_ack: once imem_req rises, imem_req and imem_addr stay
//     constant until the cycle imem_ack=1; that cycle completes the request
//     and imem_rdata is sampled (or discarded if a redirect squashes it).
//   instr_valid/instr_ready: a transfer to decode happens on a cycle with
//     instr_valid=1 and instr_ready=1 and no branch_taken; while instr_valid=1
//     and no transfer happens, instr_data/instr_pc stay constant. A branch in
//     the same cycle squashes the held word instead of transferring it.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_seq,
  output logic [31:0] pc_branch,
  output logic        pc_select,
  input  logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic [31:0] pc_nx;
  logic [31:0] pend_target;
  logic [31:0] pend_target_nx;
  logic [31:0] instr_data_nx;
  logic [31:0] instr_pc_nx;

  // Datapath outputs toward pc_mux, IMEM and decode.
  assign pc_seq      = pc + PC_STEP;
  assign pc_select   = branch_taken | (state == DRAIN);
  assign pc_branch   = branch_taken ? branch_target : pend_target;
  assign imem_req    = (state == FETCH) || (state == DRAIN);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign dbg_state   = state;

  // Next-state logic; pc only loads pc_next on explicit update cycles.
  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    pend_target_nx = pend_target;
    instr_data_nx  = instr_data;
    instr_pc_nx    = instr_pc;
    case (state)
      IDLE: begin
        if (branch_taken) pc_nx = pc_next;
        state_nx = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          pc_nx = pc_next;
          if (!branch_taken) begin
            instr_data_nx = imem_rdata;
            instr_pc_nx   = pc;
            state_nx      = HOLD;
          end
        end else if (branch_taken) begin
          // The request must complete before the redirect can be applied.
          pend_target_nx = branch_target;
          state_nx       = DRAIN;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_nx    = pc_next;
          state_nx = FETCH;
        end else if (instr_ready) begin
          state_nx = FETCH;
        end
      end
      DRAIN: begin
        if (branch_taken) pend_target_nx = branch_target;
        if (imem_ack) begin
          // pc_select is forced high here, so pc_next carries the newest target.
          pc_nx    = pc_next;
          state_nx = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pend_target <= 32'h0;
      instr_data  <= 32'h0;
      instr_pc    <= 32'h0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      pend_target <= pend_target_nx;
      instr_data  <= instr_data_nx;
      instr_pc    <= instr_pc_nx;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios, a behavioural model checked on
// every cycle, an accepted-instruction scoreboard and literal spot checks.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc_seq;
  logic [31:0] pc_branch;
  logic        pc_select;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc_seq(pc_seq), .pc_branch(pc_branch), .pc_select(pc_select),
    .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Instruction word the IMEM returns for an address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // External pc_mux and IMEM data path.
  assign pc_next    = pc_select ? pc_branch : pc_seq;
  assign imem_rdata = imem_ack ? word_at(imem_addr) : 32'hDEAD_BEEF;

  // Behavioural model: what the fetcher must present, tracked as
  // "request outstanding", "redirect owed", "word held" flags plus pc.
  logic        m_valid = 1'b0;
  logic        m_starting;
  logic        m_req;
  logic        m_redir;
  logic        m_hold;
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  logic [31:0] m_data;
  logic [31:0] m_ipc;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1; m_starting = 1'b1; m_req = 1'b0; m_redir = 1'b0;
      m_hold = 1'b0; m_pc = 32'h0; m_pend = 32'h0; m_data = 32'h0; m_ipc = 32'h0;
    end else if (m_valid) begin
      if (m_starting) begin
        if (branch_taken) m_pc = branch_target;
        m_starting = 1'b0;
        m_req = 1'b1;
      end else if (m_hold) begin
        if (branch_taken) begin
          m_pc = branch_target; m_hold = 1'b0; m_req = 1'b1;
        end else if (instr_ready) begin
          m_hold = 1'b0; m_req = 1'b1;
        end
      end else if (m_redir) begin
        if (imem_ack) begin
          m_pc = branch_taken ? branch_target : m_pend;
          m_redir = 1'b0;
        end
        if (branch_taken) m_pend = branch_target;
      end else if (m_req) begin
        if (imem_ack && branch_taken) begin
          m_pc = branch_target;
        end else if (imem_ack) begin
          m_data = word_at(m_pc); m_ipc = m_pc; m_pc = m_pc + 32'd4;
          m_hold = 1'b1; m_req = 1'b0;
        end else if (branch_taken) begin
          m_redir = 1'b1; m_pend = branch_target;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process: DUT against model every cycle, plus the scoreboard.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
      chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_hold});
      chk("pc_seq", pc_seq, m_pc + 32'd4);
      chk("pc_select", {31'b0, pc_select}, {31'b0, branch_taken | m_redir});
      chk("pc_branch", pc_branch, branch_taken ? branch_target : m_pend);
      if (m_hold) begin
        chk("instr_data", instr_data, m_data);
        chk("instr_pc", instr_pc, m_ipc);
      end
      if (!rst && instr_valid && instr_ready && !branch_taken) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_accept", instr_pc, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("sb_pc", instr_pc, e);
          chk("sb_data", instr_data, word_at(e));
        end
      end
    end
  end

  // Driver: apply one cycle of inputs, then return to quiet inputs.
  task automatic cyc(input logic bt, input logic [31:0] tgt, input logic ack, input logic rdy);
    branch_taken  = bt;
    branch_target = tgt;
    imem_ack      = ack;
    instr_ready   = rdy;
    @(posedge clk);
    #1;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    imem_ack      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; branch_taken = 1'b0; branch_target = 32'h0;
    imem_ack = 1'b0; instr_ready = 1'b1;

    // 1. reset and sequential fetches 0,4,8,C
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst_instr_data", instr_data, 32'h0);
    chk("rst_pc_branch", pc_branch, 32'h0);
    rst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", imem_addr, 32'h4 * i);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 1, 1);
      chk("seq_instr_pc", instr_pc, 32'h4 * i);
      cyc(0, 0, 0, 1);
    end
    chk("seq_next_addr", imem_addr, 32'h10);

    // 2. stall in HOLD for 5 cycles
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, instr_valid}, 32'h1);
      chk("stall_req", {31'b0, imem_req}, 32'h0);
      chk("stall_instr_pc", instr_pc, 32'h10);
      chk("stall_pc", imem_addr, 32'h14);
      cyc(0, 0, 0, 0);
    end

    // 3. branch to 0x80 while HOLD with ready: held word squashed
    cyc(1, 32'h80, 0, 1);
    chk("br_hold_addr", imem_addr, 32'h80);
    chk("br_hold_valid", {31'b0, instr_valid}, 32'h0);
    exp_q.push_back(32'h80);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    // ack and branch together in FETCH: word dropped, fetch 0x10
    cyc(1, 32'h10, 1, 1);
    chk("ack_br_addr", imem_addr, 32'h10);

    // 4. branch to 0x100 while waiting at 0x10, ack 3 cycles later
    cyc(1, 32'h100, 0, 0);
    for (int i = 0; i < 2; i++) begin
      chk("drain_addr", imem_addr, 32'h10);
      chk("drain_req", {31'b0, imem_req}, 32'h1);
      cyc(0, 0, 0, 0);
    end
    cyc(0, 0, 1, 0);
    chk("drain_next", imem_addr, 32'h100);
    chk("drain_no_valid", {31'b0, instr_valid}, 32'h0);

    // 5. multiple redirects during DRAIN; latest wins
    cyc(1, 32'h1F0, 0, 0);
    cyc(1, 32'h200, 0, 0);
    chk("drain_pend", pc_branch, 32'h200);
    cyc(0, 0, 0, 0);
    cyc(1, 32'h300, 1, 0);
    chk("drain_latest", imem_addr, 32'h300);
    exp_q.push_back(32'h300);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);

    // 6. wrap from 0xFFFFFFFC to 0
    cyc(1, 32'hFFFF_FFFC, 1, 1);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_seq", pc_seq, 32'h0);
    exp_q.push_back(32'hFFFF_FFFC);
    cyc(0, 0, 1, 1);
    chk("wrap_pc", imem_addr, 32'h0);
    cyc(0, 0, 0, 1);

    // reset during DRAIN then late ack in IDLE
    cyc(1, 32'h400, 0, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    chk("rst_drain_req", {31'b0, imem_req}, 32'h0);
    cyc(0, 0, 1, 0);
    chk("late_ack_addr", imem_addr, 32'h0);
    chk("late_ack_valid", {31'b0, instr_valid}, 32'h0);
    chk("late_ack_req", {31'b0, imem_req}, 32'h1);
    exp_q.push_back(32'h0);
    cyc(0, 0, 1, 1);
    chk("restart_instr_pc", instr_pc, 32'h0);
    cyc(0, 0, 0, 1);

    // branch while IDLE
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    cyc(1, 32'h40, 0, 1);
    chk("idle_br_addr", imem_addr, 32'h40);
    exp_q.push_back(32'h40);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    chk("sb_leftover", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
